apple_spawner: RTL and testbench
================================

Name: apple_spawner

Overview:
Sequential placement engine that produces the apple position consumed by the apple renderer (x_start/y_start, tile-aligned, SIZE px grid). It uses a 16-bit LFSR to draw random tiles, rejects out-of-field draws, and queries the snake-body checker for occupancy over a one-cycle query interface. On reset it places the first apple automatically, then re-spawns after each "eaten" pulse from the game logic.

Parameters:
BIT, 10, pixel coordinate width
SIZE, 20, tile size in px (apple is SIZE x SIZE)
H_TILES, 32, playfield width in tiles (640/20)
V_TILES, 24, playfield height in tiles (480/20)
MAX_TRIES, 16, blocked candidates tolerated before forced placement
SEED, 16'hACE1, LFSR reset value (0 is replaced by 16'h0001)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
eaten  in  1  one-cycle pulse: apple consumed, request a new position
cand_x  out  BIT  candidate x pixel (tile*SIZE), valid when cand_valid
cand_y  out  BIT  candidate y pixel
cand_valid  out  1  occupancy query strobe (CHECK state)
cand_blocked  in  1  combinational answer from snake checker, sampled in the cand_valid cycle
x_start  out  BIT  placed apple x pixel
y_start  out  BIT  placed apple y pixel
apple_valid  out  1  placed position valid; renderer must gate drawing with it
busy  out  1  high in DRAW/CHECK/PLACE
placed  out  1  one-cycle pulse when a new position is committed
forced  out  1  sticky until next eaten: last placement ignored a blocked answer

Behaviour:
- Reset (async): state=DRAW, lfsr=SEED, tries=0, x_start=y_start=0, cand_x=cand_y=0, apple_valid=0, placed=0, forced=0. busy=1 on the first cycle after release.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts left, feedback into bit 0. Never reaches 0.
- States: IDLE, DRAW, CHECK, PLACE (encoding in package).
- DRAW: lfsr steps; tx=lfsr[4:0], ty=lfsr[9:5] of the new value. If tx>=H_TILES or ty>=V_TILES, stay in DRAW (a reject, not counted in tries). Otherwise cand_x<=tx*SIZE, cand_y<=ty*SIZE, go to CHECK.
- Arithmetic: the tile*SIZE products are computed at BIT width, with no overflow for the defaults (max 31*20=620, 23*20=460). Tile fields are clog2(H_TILES) and clog2(V_TILES) wide.
- CHECK (1 cycle): cand_valid=1.
  - If cand_blocked=0, go to PLACE.
  - If cand_blocked=1 and tries<MAX_TRIES-1, increment tries and go to DRAW.
  - If cand_blocked=1 and tries==MAX_TRIES-1, set forced=1 and go to PLACE.
- PLACE (1 cycle): x_start<=cand_x, y_start<=cand_y, apple_valid<=1, placed pulses (registered, visible the cycle after PLACE), go to IDLE.
- IDLE: busy=0. On eaten: apple_valid<=0, forced<=0, tries<=0, go to DRAW.
- Latency: eaten to placed is 3 cycles minimum (DRAW, CHECK, PLACE, pulse), plus 1 per reject and 2 per blocked retry.
- eaten while busy: ignored, no queueing.
- eaten in the same cycle as reset deassertion: ignored (state is DRAW).
- x_start/y_start hold their old value while apple_valid=0 and until the next PLACE.
- Reset mid-operation: immediate return to reset values. The LFSR sequence restarts from SEED.

Optional Feature:
SPAWN_ENTROPY_EN
- Defined: lfsr advances every clock in every state, so spawn positions depend on player timing.
- Undefined: lfsr advances only in DRAW. The sequence is fully deterministic from SEED, which the golden-model checks rely on.
- The DRAW logic uses the LFSR value after the step in both modes.

Decomposition:
- Package snake_pkg: the state typedef (IDLE/DRAW/CHECK/PLACE), LFSR tap mask, default SEED, and playfield tile constants H_TILES, V_TILES, SIZE. These are shared with the renderer and the snake body checker.
- Sub-module lfsr16 (clk, reset, step, seed, value).
- Tile-to-pixel multiply stays inline.

Test Plan:
- Reset: hold reset 3 cycles with cand_blocked=0 -> during reset apple_valid=0, x_start=y_start=0. After release, placed pulses with apple_valid=1 within 3+rejects cycles; x_start%20==0, y_start%20==0, and the position matches the golden LFSR model for SEED=16'hACE1.
- Range sweep: 1000 eaten pulses, each issued 2 cycles after placed -> every x_start<=620 and y_start<=460; no placed while busy; each cand_valid precedes its PLACE by 1 cycle.
- Blocked retry: cand_blocked=1 for the first 3 queries, then 0 -> exactly 4 cand_valid strobes; the 4th candidate is placed; forced=0.
- Forced placement: cand_blocked=1 always -> exactly 16 cand_valid strobes, placed pulses, forced=1, and the position equals the 16th candidate. forced clears on the next eaten.
- Eaten while busy: pulse eaten during CHECK -> ignored; a single placed follows; the placement sequence is unchanged versus the golden model.
- Reset mid-DRAW: assert reset during a respawn -> outputs return to reset values asynchronously (same cycle); after release, the first placement equals the post-reset first placement from scenario 1.

Source files
------------

// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - playfield constants, spawner state type and LFSR step shared by the snake blocks
package snake_pkg;

   localparam int SIZE    = 20;
   localparam int H_TILES = 32;
   localparam int V_TILES = 24;

   // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
   localparam logic [15:0] LFSR_TAPS = 16'hB400;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAW  = 2'd1,
      CHECK = 2'd2,
      PLACE = 2'd3
   } spawn_state_t;

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return {v[14:0], ^(v & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - 16-bit Fibonacci LFSR with step enable; a zero seed is replaced by 1
module lfsr16 (
   input  logic        clk,
   input  logic        reset,
   input  logic        step,
   input  logic [15:0] seed,
   output logic [15:0] value
);
   import snake_pkg::*;

   logic [15:0] start;

   assign start = (seed == 16'h0000) ? 16'h0001 : seed;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         value <= start;
      else if (step)
         value <= lfsr_next(value);
   end

endmodule

// File: rtl/apple_spawner.sv
// rtl/apple_spawner.sv - random apple placement avoiding the snake body; SPAWN_ENTROPY_EN makes the LFSR free-run
module apple_spawner #(
   parameter int          BIT       = 10,
   parameter int          SIZE      = snake_pkg::SIZE,
   parameter int          H_TILES   = snake_pkg::H_TILES,
   parameter int          V_TILES   = snake_pkg::V_TILES,
   parameter int          MAX_TRIES = 16,
   parameter logic [15:0] SEED      = snake_pkg::LFSR_SEED
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           eaten,
   output logic [BIT-1:0] cand_x,
   output logic [BIT-1:0] cand_y,
   output logic           cand_valid,
   input  logic           cand_blocked,
   output logic [BIT-1:0] x_start,
   output logic [BIT-1:0] y_start,
   output logic           apple_valid,
   output logic           busy,
   output logic           placed,
   output logic           forced
);
   import snake_pkg::*;

   localparam int TXW = $clog2(H_TILES);
   localparam int TYW = $clog2(V_TILES);
   localparam int TRW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

   spawn_state_t   state, state_next;
   logic [15:0]    lfsr_value, lfsr_stepped;
   logic           step;
   logic [TXW-1:0] tx;
   logic [TYW-1:0] ty;
   logic           in_field, last_try;
   logic [TRW-1:0] tries;
   logic           lfsr_unused;

`ifdef SPAWN_ENTROPY_EN
   assign step = 1'b1;
`else
   assign step = (state == DRAW);
`endif

   lfsr16 u_lfsr (
      .clk   (clk),
      .reset (reset),
      .step  (step),
      .seed  (SEED),
      .value (lfsr_value)
   );

   // DRAW decodes the value the register is about to take, so no extra cycle is spent
   assign lfsr_stepped = lfsr_next(lfsr_value);
   assign tx           = lfsr_stepped[TXW-1:0];
   assign ty           = lfsr_stepped[TXW +: TYW];
   assign lfsr_unused  = ^lfsr_stepped[15:TXW+TYW];
   assign in_field     = (32'(tx) < 32'(H_TILES)) && (32'(ty) < 32'(V_TILES));
   assign last_try     = (32'(tries) == 32'(MAX_TRIES - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= DRAW;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (eaten) state_next = DRAW;
         DRAW:    if (in_field) state_next = CHECK;
         CHECK:   state_next = (!cand_blocked || last_try) ? PLACE : DRAW;
         PLACE:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy       = (state != IDLE);
      cand_valid = (state == CHECK);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cand_x      <= '0;
         cand_y      <= '0;
         x_start     <= '0;
         y_start     <= '0;
         tries       <= '0;
         apple_valid <= 1'b0;
         placed      <= 1'b0;
         forced      <= 1'b0;
      end else begin
         placed <= (state == PLACE);
         case (state)
            IDLE: begin
               if (eaten) begin
                  apple_valid <= 1'b0;
                  forced      <= 1'b0;
                  tries       <= '0;
               end
            end
            DRAW: begin
               if (in_field) begin
                  cand_x <= BIT'(tx) * BIT'(SIZE);
                  cand_y <= BIT'(ty) * BIT'(SIZE);
               end
            end
            CHECK: begin
               if (cand_blocked) begin
                  if (last_try)
                     forced <= 1'b1;
                  else
                     tries <= tries + TRW'(1);
               end
            end
            PLACE: begin
               x_start     <= cand_x;
               y_start     <= cand_y;
               apple_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_apple_spawner.sv
// tb/tb_apple_spawner.sv - self-checking bench for apple_spawner against a golden LFSR placement model
module tb_apple_spawner;

   localparam int          BIT       = 10;
   localparam int          MAX_TRIES = 16;
   localparam logic [15:0] SEED      = 16'hACE1;

   typedef struct {
      int x;
      int y;
      bit forced;
   } pos_t;

   typedef struct {
      int nblock;
      int exp_queries;
      bit exp_forced;
   } vec_t;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           eaten = 1'b0;
   logic           cand_blocked;
   logic [BIT-1:0] cand_x, cand_y, x_start, y_start;
   logic           cand_valid, apple_valid, busy, placed, forced;

   int          checks = 0;
   int          errors = 0;
   int          total_q = 0;
   int          block_until = 0;
   int          cyc = 0;
   int          last_cv = -100;
   int          placed_cnt = 0;
   logic [15:0] model;
   pos_t        cand_q[$];
   pos_t        place_q[$];
   pos_t        first_pos;

   always #5 clk = ~clk;

   // snake checker stand-in: the next block_until-total_q queries answer "occupied"
   assign cand_blocked = (total_q < block_until);

   apple_spawner #(
      .BIT       (BIT),
      .MAX_TRIES (MAX_TRIES),
      .SEED      (SEED)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .eaten        (eaten),
      .cand_x       (cand_x),
      .cand_y       (cand_y),
      .cand_valid   (cand_valid),
      .cand_blocked (cand_blocked),
      .x_start      (x_start),
      .y_start      (y_start),
      .apple_valid  (apple_valid),
      .busy         (busy),
      .placed       (placed),
      .forced       (forced)
   );

   always @(posedge clk) begin
      if (!reset && cand_valid)
         total_q <= total_q + 1;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: actual %0d required %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_cand(output int x, output int y, output int rej);
      int tx, ty;
      rej = 0;
      forever begin
         model = {model[14:0], model[15] ^ model[13] ^ model[12] ^ model[10]};
         tx = int'(model[4:0]);
         ty = int'(model[9:5]);
         if (tx < 32 && ty < 24) break;
         rej++;
      end
      x = tx * 20;
      y = ty * 20;
   endtask

   task automatic expect_spawn(input int nblock, output int lat, output pos_t p);
      int nq, x, y, rej;
      nq = (nblock >= MAX_TRIES) ? MAX_TRIES : nblock + 1;
      block_until = total_q + nblock;
      lat = nq + 1;
      for (int i = 0; i < nq; i++) begin
         model_cand(x, y, rej);
         lat += rej + 1;
         p.x = x;
         p.y = y;
         p.forced = 1'b0;
         cand_q.push_back(p);
      end
      p.forced = (nblock >= MAX_TRIES);
      place_q.push_back(p);
   endtask

   task automatic pulse_eaten();
      eaten = 1'b1;
      tick();
      eaten = 1'b0;
   endtask

   task automatic wait_placed(input string name, output int n);
      n = 0;
      while (n < 300) begin
         tick();
         n++;
         if (placed) return;
      end
      chk({name, "_timeout"}, 0, 1);
   endtask

   always @(negedge clk) begin
      pos_t e;
      cyc++;
      if (!reset) begin
         if (cand_valid) begin
            last_cv = cyc;
            if (cand_q.size() == 0) begin
               chk("cand_unexpected", 1, 0);
            end else begin
               e = cand_q.pop_front();
               chk("cand_x", int'(cand_x), e.x);
               chk("cand_y", int'(cand_y), e.y);
            end
         end
         if (placed) begin
            placed_cnt++;
            chk("placed_while_busy", int'(busy), 0);
            chk("cand_to_placed", cyc - last_cv, 2);
            chk("placed_apple_valid", int'(apple_valid), 1);
            chk("x_in_range", int'(x_start <= 10'd620), 1);
            chk("y_in_range", int'(y_start <= 10'd460), 1);
            if (place_q.size() == 0) begin
               chk("placed_unexpected", 1, 0);
            end else begin
               e = place_q.pop_front();
               chk("x_start", int'(x_start), e.x);
               chk("y_start", int'(y_start), e.y);
               chk("forced", int'(forced), int'(e.forced));
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t vt[8];
      int   n, lat, start_q, pc;
      pos_t p;

      vt[0] = '{0, 1, 1'b0};
      vt[1] = '{3, 4, 1'b0};
      vt[2] = '{1, 2, 1'b0};
      vt[3] = '{15, 16, 1'b0};
      vt[4] = '{16, 16, 1'b1};
      vt[5] = '{0, 1, 1'b0};
      vt[6] = '{40, 16, 1'b1};
      vt[7] = '{14, 15, 1'b0};

      // reset held three cycles
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_apple_valid", int'(apple_valid), 0);
         chk("rst_x_start", int'(x_start), 0);
         chk("rst_y_start", int'(y_start), 0);
         chk("rst_placed", int'(placed), 0);
         chk("rst_forced", int'(forced), 0);
         chk("rst_cand_valid", int'(cand_valid), 0);
      end
      model = SEED;
      expect_spawn(0, lat, first_pos);
      start_q = total_q;
      reset = 1'b0;
      chk("post_rst_busy", int'(busy), 1);
      wait_placed("first", n);
      chk("first_latency", n, lat);
      chk("first_queries", total_q - start_q, 1);

      // table of blocked-answer patterns
      for (int i = 0; i < 8; i++) begin
         tick();
         tick();
         expect_spawn(vt[i].nblock, lat, p);
         start_q = total_q;
         pulse_eaten();
         chk("row_forced_cleared", int'(forced), 0);
         chk("row_apple_valid_cleared", int'(apple_valid), 0);
         chk("row_busy", int'(busy), 1);
         wait_placed("row", n);
         chk("row_latency", n, lat);
         chk("row_queries", total_q - start_q, vt[i].exp_queries);
         chk("row_forced", int'(forced), int'(vt[i].exp_forced));
      end

      // eaten pulsed during CHECK must be dropped
      tick();
      tick();
      expect_spawn(0, lat, p);
      pc = placed_cnt;
      pulse_eaten();
      n = 0;
      while (!cand_valid && n < 40) begin
         tick();
         n++;
      end
      chk("busy_reached_check", int'(cand_valid), 1);
      eaten = 1'b1;
      tick();
      eaten = 1'b0;
      wait_placed("busy", n);
      repeat (6) tick();
      chk("busy_single_placed", placed_cnt - pc, 1);
      chk("busy_back_idle", int'(busy), 0);
      chk("busy_queue_drained", place_q.size(), 0);

      // range sweep
      for (int k = 0; k < 1000; k++) begin
         tick();
         tick();
         expect_spawn(int'($urandom_range(0, 2)), lat, p);
         pulse_eaten();
         wait_placed("sweep", n);
      end

      // asynchronous reset during a respawn
      tick();
      tick();
      expect_spawn(0, lat, p);
      pulse_eaten();
      chk("mid_in_draw", int'(busy && !cand_valid), 1);
      reset = 1'b1;
      #1;
      chk("mid_x_start", int'(x_start), 0);
      chk("mid_y_start", int'(y_start), 0);
      chk("mid_cand_x", int'(cand_x), 0);
      chk("mid_cand_y", int'(cand_y), 0);
      chk("mid_apple_valid", int'(apple_valid), 0);
      chk("mid_placed", int'(placed), 0);
      chk("mid_forced", int'(forced), 0);
      cand_q.delete();
      place_q.delete();
      tick();
      tick();
      model = SEED;
      expect_spawn(0, lat, p);
      pc = placed_cnt;
      eaten = 1'b1;
      reset = 1'b0;
      tick();
      eaten = 1'b0;
      wait_placed("mid", n);
      chk("mid_latency", n + 1, lat);
      chk("mid_first_x", int'(x_start), first_pos.x);
      chk("mid_first_y", int'(y_start), first_pos.y);
      repeat (6) tick();
      chk("mid_single_placed", placed_cnt - pc, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
